// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern source (INCR, LFSR, WALK1, CONST) with per-packet mode/length capture.
// Optional macro AXIS_PATTERN_GEN_TUSER_EN adds a start-of-frame tuser output.
module axis_pattern_gen #(
    parameter int          N     = 1,
    parameter int          LEN_W = 16,
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             tvalid,
    input  logic             tready,
    output logic [8*N-1:0]   tdata,
    output logic             tlast,
    output logic             busy,
    output logic [15:0]      pkt_count
`ifdef AXIS_PATTERN_GEN_TUSER_EN
    ,
    output logic             tuser
`endif
);
    localparam int               DW    = 8 * N;
    localparam logic [31:0]      POLY  = 32'h8020_0003;
    localparam logic [LEN_W-1:0] ONE_L = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic             armed_q;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             hs;
    logic             start;
    logic [LEN_W-1:0] len_new;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
    logic             sof_q, sof_d;
`endif

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [1:0] m,
                                              input logic [LEN_W-1:0] b,
                                              input logic [31:0] s);
        logic [DW-1:0] d;
        d = '0;
        case (m)
            2'd0: for (int i = 0; i < N; i++)
                d[8*i +: 8] = 8'(32'(b) * 32'(N) + 32'(i));
            2'd1: for (int i = 0; i < N; i++)
                d[8*i +: 8] = s[8*(i % 4) +: 8];
            2'd2: d = {{(DW-1){1'b0}}, 1'b1} << (32'(b) % 32'(DW));
            default: d = {N{8'hA5}};
        endcase
        return d;
    endfunction

    assign hs      = (state_q == SEND) && tready;
    assign len_new = (pkt_len == '0) ? ONE_L : pkt_len;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        beat_d  = beat_q;
        lfsr_d  = hs ? lfsr_next(lfsr_q) : lfsr_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        cnt_d   = (hs && tlast_q) ? cnt_q + 16'd1 : cnt_q;
        start   = 1'b0;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
        sof_d   = sof_q;
`endif
        case (state_q)
            IDLE: start = enable && armed_q;
            SEND: begin
                if (hs && tlast_q) begin
                    start = enable;
                    if (!enable) begin
                        state_d = IDLE;
                        tlast_d = 1'b0;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
                        sof_d   = 1'b0;
`endif
                    end
                end else if (hs) begin
                    beat_d  = beat_q + ONE_L;
                    tdata_d = pattern(mode_q, beat_q + ONE_L, lfsr_d);
                    tlast_d = ((beat_q + ONE_L) == (len_q - ONE_L));
`ifdef AXIS_PATTERN_GEN_TUSER_EN
                    sof_d   = 1'b0;
`endif
                end
            end
            default: ;
        endcase
        // New packet: capture mode/length and present beat 0 from the post-step LFSR state.
        if (start) begin
            state_d = SEND;
            mode_d  = mode;
            len_d   = len_new;
            beat_d  = '0;
            tdata_d = pattern(mode, '0, lfsr_d);
            tlast_d = (len_new == ONE_L);
`ifdef AXIS_PATTERN_GEN_TUSER_EN
            sof_d   = 1'b1;
`endif
        end
    end

    // armed_q holds off packet start for the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            mode_q  <= 2'd0;
            len_q   <= ONE_L;
            beat_q  <= '0;
            lfsr_q  <= SEED;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            cnt_q   <= 16'd0;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
            sof_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            mode_q  <= mode_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            lfsr_q  <= lfsr_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            cnt_q   <= cnt_d;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
            sof_q   <= sof_d;
`endif
        end
    end

    assign tvalid    = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign tdata     = tdata_q;
    assign tlast     = tlast_q;
    assign pkt_count = cnt_q;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
    assign tuser     = sof_q;
`endif

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed testbench for axis_pattern_gen: a 4-byte and a 1-byte instance share one stimulus stream.
module tb_axis_pattern_gen;
    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] pkt_len;
    logic        tready;

    logic        tvalid4, tlast4, busy4;
    logic [31:0] tdata4;
    logic [15:0] cnt4;
    logic        tvalid1, tlast1, busy1;
    logic [7:0]  tdata1;
    logic [15:0] cnt1;
`ifdef AXIS_PATTERN_GEN_TUSER_EN
    logic        tuser4, tuser1;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_incr4 [3];
    logic [7:0]  exp_walk1 [10];
    logic [31:0] exp_lfsr  [8];
    int          k;

    axis_pattern_gen #(.N(4)) u4 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode), .pkt_len(pkt_len),
        .tvalid(tvalid4), .tready(tready), .tdata(tdata4), .tlast(tlast4), .busy(busy4),
        .pkt_count(cnt4)
`ifdef AXIS_PATTERN_GEN_TUSER_EN
        , .tuser(tuser4)
`endif
    );

    axis_pattern_gen #(.N(1)) u1 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode), .pkt_len(pkt_len),
        .tvalid(tvalid1), .tready(tready), .tdata(tdata1), .tlast(tlast1), .busy(busy1),
        .pkt_count(cnt1)
`ifdef AXIS_PATTERN_GEN_TUSER_EN
        , .tuser(tuser1)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_incr4 = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
        exp_walk1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        exp_lfsr  = '{32'hFFFFFFFF, 32'hFFDFFFFC, 32'h7FEFFFFE, 32'h3FF7FFFF,
                      32'h9FDBFFFC, 32'h4FEDFFFE, 32'h27F6FFFF, 32'h93DB7FFC};

        aresetn = 1'b0; enable = 1'b0; mode = 2'd0; pkt_len = 16'd0; tready = 1'b0;
        tick;
        tick;
        check("rst_tvalid", {31'd0, tvalid4}, 32'd0);
        check("rst_tdata",  tdata4, 32'd0);
        check("rst_tlast",  {31'd0, tlast4}, 32'd0);
        check("rst_busy",   {31'd0, busy4}, 32'd0);
        check("rst_cnt",    {16'd0, cnt4}, 32'd0);
        check("rst_tdata1", {24'd0, tdata1}, 32'd0);
        aresetn = 1'b1;
        tick;

        // INCR, 3-beat packet from a one-cycle enable pulse
        mode = 2'd0; pkt_len = 16'd3; tready = 1'b1; enable = 1'b1;
        tick;
        enable = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("incr_tvalid", {31'd0, tvalid4}, 32'd1);
            check("incr_tdata4", tdata4, exp_incr4[b]);
            check("incr_tdata1", {24'd0, tdata1}, b);
            check("incr_tlast",  {31'd0, tlast4}, (b == 2) ? 32'd1 : 32'd0);
            tick;
        end
        check("incr_idle",  {31'd0, tvalid4}, 32'd0);
        check("incr_busy",  {31'd0, busy4}, 32'd0);
        check("incr_cnt",   {16'd0, cnt4}, 32'd1);

        // WALK1, length 10, tready toggling; mode/length change mid-packet must be ignored
        mode = 2'd2; pkt_len = 16'd10; tready = 1'b0; enable = 1'b1;
        tick;
        enable = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            tready = c[0];
            if (c == 5) begin
                mode = 2'd3; pkt_len = 16'd1;
            end
            check("walk_tvalid", {31'd0, tvalid1}, 32'd1);
            check("walk_tdata1", {24'd0, tdata1}, {24'd0, exp_walk1[k]});
            check("walk_tlast",  {31'd0, tlast1}, (k == 9) ? 32'd1 : 32'd0);
            tick;
            if (tready) k++;
        end
        check("walk_idle", {31'd0, tvalid1}, 32'd0);
        check("walk_cnt",  {16'd0, cnt1}, 32'd2);
        check("walk_busy", {31'd0, busy1}, 32'd0);

        // Reset asserted on beat 2 of a 5-beat packet with tready low
        mode = 2'd0; pkt_len = 16'd5; tready = 1'b1; enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        tick;
        tready = 1'b0;
        check("stall_tdata", tdata4, 32'h0B0A0908);
        tick;
        check("stall_hold",  tdata4, 32'h0B0A0908);
        check("stall_tlast", {31'd0, tlast4}, 32'd0);
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", {31'd0, tvalid4}, 32'd0);
        check("arst_tdata",  tdata4, 32'd0);
        check("arst_cnt",    {16'd0, cnt4}, 32'd0);
        check("arst_busy",   {31'd0, busy4}, 32'd0);
        enable = 1'b1; mode = 2'd1; pkt_len = 16'd4; tready = 1'b1;
        tick;
        aresetn = 1'b1;
        tick;
        check("rel_first_edge", {31'd0, tvalid4}, 32'd0);
        tick;

        // LFSR, two back-to-back 4-beat packets
        for (int b = 0; b < 8; b++) begin
            if (b == 5) enable = 1'b0;
            check("lfsr_tvalid", {31'd0, tvalid4}, 32'd1);
            check("lfsr_tdata4", tdata4, exp_lfsr[b]);
            check("lfsr_tdata1", {24'd0, tdata1}, {24'd0, exp_lfsr[b][7:0]});
            check("lfsr_tlast",  {31'd0, tlast4}, (b == 3 || b == 7) ? 32'd1 : 32'd0);
`ifdef AXIS_PATTERN_GEN_TUSER_EN
            check("lfsr_tuser",  {31'd0, tuser4}, (b == 0 || b == 4) ? 32'd1 : 32'd0);
`endif
            tick;
        end
        check("lfsr_idle", {31'd0, tvalid4}, 32'd0);
        check("lfsr_cnt",  {16'd0, cnt4}, 32'd2);

        // CONST, pkt_len 0 -> single-beat packets; run the counter through its wrap
        mode = 2'd3; pkt_len = 16'd0; tready = 1'b1; enable = 1'b1;
        tick;
        check("const_tdata4", tdata4, 32'hA5A5A5A5);
        check("const_tlast",  {31'd0, tlast4}, 32'd1);
        check("const_cnt",    {16'd0, cnt4}, 32'd2);
        tick;
        check("const_tdata1", {24'd0, tdata1}, 32'hA5);
        check("const_tlast1", {31'd0, tlast1}, 32'd1);
        check("const_cnt3",   {16'd0, cnt4}, 32'd3);
        for (int i = 0; i < 65532; i++) tick;
        check("wrap_ffff",   {16'd0, cnt4}, 32'h0000FFFF);
        check("wrap_tvalid", {31'd0, tvalid4}, 32'd1);
        tick;
        check("wrap_zero",   {16'd0, cnt4}, 32'd0);
        check("wrap_zero1",  {16'd0, cnt1}, 32'd0);
        enable = 1'b0;
        tick;
        check("const_idle",  {31'd0, tvalid4}, 32'd0);
        check("const_cnt1",  {16'd0, cnt4}, 32'd1);
`ifdef AXIS_PATTERN_GEN_TUSER_EN
        check("idle_tuser",  {31'd0, tuser1}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_pattern_gen.md
AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 The block SHALL have parameter N, default 1, meaning tdata width in bytes (1..64).
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning width of pkt_len.
REQ-003 The block SHALL have parameter SEED, default 32'hFFFF_FFFF, meaning LFSR reset value (0 illegal).
REQ-004 aclk  input  1  clock; all logic rising-edge.
REQ-005 aresetn  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  start/continue packet generation.
REQ-007 mode  input  2  pattern: 0 INCR, 1 LFSR, 2 WALK1, 3 CONST.
REQ-008 pkt_len  input  LEN_W  beats per packet; 0 treated as 1.
REQ-009 tvalid  output  1  AXIS valid.
REQ-010 tready  input  1  AXIS ready.
REQ-011 tdata  output  8*N  AXIS data.
REQ-012 tlast  output  1  last beat of packet.
REQ-013 busy  output  1  high while in SEND.
REQ-014 pkt_count  output  16  completed packets, wraps 0xFFFF->0.

Function
REQ-015 FSM SHALL have states IDLE and SEND; IDLE->SEND when enable=1, SEND->IDLE on last-beat handshake when enable=0, SEND->SEND (next packet, no bubble) on last-beat handshake when enable=1.
REQ-016 tvalid SHALL be 1 exactly in SEND; first beat valid the cycle after enable is sampled in IDLE.
REQ-017 mode and pkt_len SHALL be captured at packet start (IDLE->SEND and SEND->SEND restart); changes mid-packet SHALL have no effect until next packet.
REQ-018 Handshake = tvalid & tready; beat counter, pattern state and tdata SHALL advance only on handshake; tdata/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-019 Deasserting enable mid-packet SHALL NOT truncate the packet; it completes all beats, then IDLE.
REQ-020 tlast SHALL be 1 on beat index L-1 (L = captured length, 0->1); L=1 gives tlast on every beat.
REQ-021 INCR: byte lane i = low 8 bits of (b*N + i), b = beat index within packet, restarting at 0 each packet.
REQ-022 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, steps once per handshake, never reset between packets; lane i = lfsr[8*(i mod 4)+:8].
REQ-023 WALK1: tdata = 1 << (b mod 8N).
REQ-024 CONST: every byte = 8'hA5.
REQ-025 pkt_count SHALL increment on each last-beat handshake.
REQ-026 Beat counter SHALL be LEN_W bits and never wrap within a packet (max L = 2^LEN_W-1).

Reset
REQ-027 aresetn low SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, busy=0, pkt_count=0, beat counter=0, lfsr=SEED, including mid-packet; tuser=0 when present.
REQ-028 After aresetn release, first tvalid SHALL be no earlier than the second aclk edge.

Configuration
REQ-029 With macro AXIS_PATTERN_GEN_TUSER_EN defined, the block SHALL have output tuser (1 bit) high only on beat 0 of each packet (start-of-frame), following tdata stability rules.
REQ-030 Without AXIS_PATTERN_GEN_TUSER_EN, tuser port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 N=4, mode=0, pkt_len=3, tready=1, enable pulsed 1 cycle -> 3 beats 0x03020100, 0x07060504, 0x0B0A0908, tlast on beat 3, then IDLE, pkt_count=1.
REQ-032 N=1, mode=2, pkt_len=10, tready toggling 1/0 -> data 01,02,04,...,80,01,02 with no value skipped or repeated, tdata stable during tready=0.
REQ-033 mode=1, SEED default, N=4, enable held 2 packets of 4 -> 8 beats match reference LFSR model, sequence continues across packet boundary, no idle cycle between packets.
REQ-034 pkt_len=0, mode=3 -> single-beat packets 0xA5..., tlast=1 every beat; pkt_count wraps 0xFFFF->0x0000 after 65536 packets.
REQ-035 aresetn asserted on beat 2 of 5 with tready=0 -> tvalid/tdata/pkt_count 0 immediately (same cycle, before clock); after release with enable=1 new packet starts at beat 0.
REQ-036 With AXIS_PATTERN_GEN_TUSER_EN, pkt_len=2 back-to-back -> tuser 1,0,1,0; change mode mid-packet -> effect only from next packet.
